// File: rtl/serial_nibble_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit ripple slice reused over WIDTH/4 cycles, LSB nibble first.
// Optional signed-overflow flag when SNA_OVERFLOW_EN is defined.

module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

// state | meaning
// IDLE  | waiting for start, result held
// BUSY  | one nibble slice per cycle, N cycles
// DONE  | result valid for one cycle, start accepted here too
module serial_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SNA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             c_out
);
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         slice_sum;
    logic               slice_c_out;
    logic               accept;
    logic               last_slice;
`ifdef SNA_OVERFLOW_EN
    logic               sign_a_q;
    logic               sign_b_q;
    logic               ovf_q;
`endif

    RCA_4bit u_slice (
        .a     (op_a_q[3:0]),
        .b     (op_b_q[3:0]),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_c_out)
    );

    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign last_slice = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SNA_OVERFLOW_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        op_a_q  <= a;
                        op_b_q  <= b;
                        res_q   <= '0;
                        carry_q <= c_in;
`ifdef SNA_OVERFLOW_EN
                        sign_a_q <= a[WIDTH-1];
                        sign_b_q <= b[WIDTH-1];
                        ovf_q    <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    res_q   <= {slice_sum, res_q[WIDTH-1:4]};
                    op_a_q  <= {4'b0000, op_a_q[WIDTH-1:4]};
                    op_b_q  <= {4'b0000, op_b_q[WIDTH-1:4]};
                    carry_q <= slice_c_out;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_slice) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef SNA_OVERFLOW_EN
                        // top slice's sum MSB is the result sign bit
                        ovf_q <= (sign_a_q == sign_b_q) && (sign_a_q != slice_sum[3]);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = res_q;
    assign c_out = carry_q;
`ifdef SNA_OVERFLOW_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder (WIDTH=16); covers ovf when SNA_OVERFLOW_EN is defined.

module tb_serial_nibble_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
`ifdef SNA_OVERFLOW_EN
    logic        ovf;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int lat;
    int n_done;

    serial_nibble_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SNA_OVERFLOW_EN
        .ovf   (ovf),
`endif
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start at the current negedge; returns negedges until done (99 on timeout).
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          output int cycles);
        start  = 1'b1;
        a      = va;
        b      = vb;
        c_in   = vc;
        cycles = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = 16'h5A5A;
                b     = 16'hA5A5;
                c_in  = 1'b0;
            end
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // all-ones with carry in
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("max_busy_c1", 32'(busy), 32'd1);
        check("max_done_c1", 32'(done), 32'd0);
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        check("max_latency", 32'(lat), 32'd5);
        check("max_busy_at_done", 32'(busy), 32'd0);
        check("max_sum", 32'(sum), 32'h0000FFFF);
        check("max_cout", 32'(c_out), 32'd1);
        @(negedge clk);
        check("max_done_width", 32'(done), 32'd0);
        check("max_sum_held", 32'(sum), 32'h0000FFFF);

        // back-to-back pair
        run_op(16'h000A, 16'h0001, 1'b1, lat);
        check("b2b1_latency", 32'(lat), 32'd5);
        check("b2b1_sum", 32'(sum), 32'h0000000C);
        check("b2b1_cout", 32'(c_out), 32'd0);
        start = 1'b1; a = 16'h1234; b = 16'h0FCC; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy_no_gap", 32'(busy), 32'd1);
        check("b2b2_done_low", 32'(done), 32'd0);
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        check("b2b2_latency", 32'(lat), 32'd5);
        check("b2b2_sum", 32'(sum), 32'h00002200);
        check("b2b2_cout", 32'(c_out), 32'd0);
        @(negedge clk);

        // start during BUSY is ignored
        start = 1'b1; a = 16'h0005; b = 16'h0007; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 99;
        for (int i = 4; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        check("ign_latency", 32'(lat), 32'd5);
        check("ign_sum", 32'(sum), 32'h0000000C);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign_extra_done", 32'(n_done), 32'd0);
        check("ign_busy_after", 32'(busy), 32'd0);

        // reset mid-operation
        start = 1'b1; a = 16'h0003; b = 16'h0004; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(c_out), 32'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b1, lat);
        check("after_abort_latency", 32'(lat), 32'd5);
        check("after_abort_sum", 32'(sum), 32'h00000008);
        @(negedge clk);

        // start and rst together: rst wins
        start = 1'b1; rst = 1'b1; a = 16'h0001; b = 16'h0001; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);

`ifdef SNA_OVERFLOW_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        check("ovf_pos_sum", 32'(sum), 32'h00008000);
        check("ovf_pos_flag", 32'(ovf), 32'd1);
        check("ovf_pos_cout", 32'(c_out), 32'd0);
        @(negedge clk);
        check("ovf_pos_held", 32'(ovf), 32'd1);
        run_op(16'h8000, 16'hFFFF, 1'b0, lat);
        check("ovf_neg_sum", 32'(sum), 32'h00007FFF);
        check("ovf_neg_flag", 32'(ovf), 32'd1);
        check("ovf_neg_cout", 32'(c_out), 32'd1);
        @(negedge clk);
        run_op(16'h1234, 16'h0FCC, 1'b0, lat);
        check("ovf_none_flag", 32'(ovf), 32'd0);
        @(negedge clk);
`endif

        // start held high: done every 5 cycles, one cycle wide
        start = 1'b1; a = 16'h0100; b = 16'h0011; c_in = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("stream_done_%0d", i), 32'(done), (i % 5 == 0) ? 32'd1 : 32'd0);
            if (done) begin
                n_done++;
                check($sformatf("stream_sum_%0d", i), 32'(sum), 32'h00000111);
            end
        end
        start = 1'b0;
        check("stream_count", 32'(n_done), 32'd3);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
